an13_decoder_1x1: RTL and testbench

// - Single-lane AN-code decoder for A=13. Input is a 6-bit codeword; valid codewords are 13*x for x=0..4.
// - Computes the quotient and remainder of the input by 13 using Barrett reduction.
// - Corrects any single-bit error in the codeword and outputs the 3-bit data value.
// - Forms the leaf decoder of the AN-code datapath; one registered output stage.

---
 rtl/an13_decoder_1x1_if.sv | 31 +++
 rtl/an13_decoder_1x1.sv | 115 +++++++++++
 tb/tb_an13_decoder_1x1.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/an13_decoder_1x1_if.sv
// Codeword/result bundle for the A=13 single-lane AN-code decoder.
//   IN0        : received 6-bit codeword (driven by master)
//   DUT0_q     : quotient floor(IN0/13)
//   DUT0_r     : remainder (syndrome) IN0 mod 13
//   DUT0_error : syndrome nonzero
//   OUT0       : corrected 3-bit data word
interface an13_decoder_1x1_if;
  logic [5:0] IN0;
  logic [2:0] DUT0_q;
  logic [3:0] DUT0_r;
  logic       DUT0_error;
  logic [2:0] OUT0;

  // Source of codewords, sink of decoded results.
  modport master (
    output IN0,
    input  DUT0_q,
    input  DUT0_r,
    input  DUT0_error,
    input  OUT0
  );

  // Decoder side.
  modport slave (
    input  IN0,
    output DUT0_q,
    output DUT0_r,
    output DUT0_error,
    output OUT0
  );
endinterface

// File: rtl/an13_decoder_1x1.sv
// Single-lane AN-code (A=13) leaf decoder with one registered output stage.
// Splits the codeword by 13 via Barrett reduction, maps the syndrome to a
// signed power-of-two error, subtracts it and, if the result is a valid
// codeword 0..52, outputs its data value; otherwise falls back to the quotient.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset, clears all outputs
//   bus   : slave modport carrying IN0 in and DUT0_q/DUT0_r/DUT0_error/OUT0 out
module an13_decoder_1x1 (
  input  logic                 clk,
  input  logic                 rst_n,
  an13_decoder_1x1_if.slave    bus
);

  localparam int unsigned A  = 13;  // AN-code constant
  localparam int unsigned W  = 6;   // codeword width
  localparam int unsigned K  = 8;   // Barrett shift
  localparam int unsigned M  = 19;  // floor(2^K / A)
  localparam int unsigned PW = 11;  // Barrett product width
  localparam int unsigned QW = 3;   // quotient / data width
  localparam int unsigned RW = 4;   // remainder width
  localparam int unsigned CW = 8;   // two's-complement correction width

  logic [PW-1:0] w_prod;
  logic [QW-1:0] w_qe;
  logic [W-1:0]  w_aqe;
  logic [W-1:0]  w_re;
  logic          w_re_ge;
  logic [QW-1:0] w_q;
  logic [RW-1:0] w_r;
  logic          w_err;
  logic [CW-1:0] w_e;
  logic [CW-1:0] w_c;
  logic          w_fix_ok;
  logic [QW-1:0] w_fix;
  logic [QW-1:0] w_out;

  logic [QW-1:0] r_q;
  logic [RW-1:0] r_r;
  logic          r_err;
  logic [QW-1:0] r_out;

  // Barrett estimate: qe never exceeds the true quotient, and is at most one short.
  assign w_prod  = PW'(bus.IN0) * PW'(M);
  assign w_qe    = QW'(w_prod >> K);
  assign w_aqe   = W'(w_qe) * W'(A);
  assign w_re    = bus.IN0 - w_aqe;
  assign w_re_ge = (w_re >= W'(A));

  // One conditional correction step finishes the exact division.
  assign w_q   = w_re_ge ? (w_qe + QW'(1)) : w_qe;
  assign w_r   = w_re_ge ? RW'(w_re - W'(A)) : RW'(w_re);
  assign w_err = (w_r != RW'(0));

  // Syndrome -> signed error 2^k (r = 2^k mod 13) or -2^k (r = 13 - 2^k mod 13).
  always_comb begin
    w_e = CW'(0);
    case (w_r)
      RW'(1):  w_e = CW'(1);
      RW'(2):  w_e = CW'(2);
      RW'(4):  w_e = CW'(4);
      RW'(8):  w_e = CW'(8);
      RW'(3):  w_e = CW'(16);
      RW'(6):  w_e = CW'(32);
      RW'(12): w_e = CW'(-1);
      RW'(11): w_e = CW'(-2);
      RW'(9):  w_e = CW'(-4);
      RW'(5):  w_e = CW'(-8);
      RW'(10): w_e = CW'(-16);
      RW'(7):  w_e = CW'(-32);
      default: w_e = CW'(0);
    endcase
  end

  // Corrected word in two's complement; negatives land at >=128 and never match.
  assign w_c = CW'(bus.IN0) - w_e;

  // Only the five codewords 0,13,26,39,52 are accepted as corrections.
  always_comb begin
    w_fix_ok = 1'b0;
    w_fix    = QW'(0);
    case (w_c)
      CW'(0):  begin w_fix_ok = 1'b1; w_fix = QW'(0); end
      CW'(13): begin w_fix_ok = 1'b1; w_fix = QW'(1); end
      CW'(26): begin w_fix_ok = 1'b1; w_fix = QW'(2); end
      CW'(39): begin w_fix_ok = 1'b1; w_fix = QW'(3); end
      CW'(52): begin w_fix_ok = 1'b1; w_fix = QW'(4); end
      default: begin w_fix_ok = 1'b0; w_fix = QW'(0); end
    endcase
  end

  // Uncorrectable words fall back to the plain quotient.
  assign w_out = w_fix_ok ? w_fix : w_q;

  // Output stage; reset takes priority over the data path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= QW'(0);
      r_r   <= RW'(0);
      r_err <= 1'b0;
      r_out <= QW'(0);
    end else begin
      r_q   <= w_q;
      r_r   <= w_r;
      r_err <= w_err;
      r_out <= w_out;
    end
  end

  assign bus.DUT0_q     = r_q;
  assign bus.DUT0_r     = r_r;
  assign bus.DUT0_error = r_err;
  assign bus.OUT0       = r_out;

endmodule

// File: tb/tb_an13_decoder_1x1.sv
// Directed self-checking bench for the A=13 AN-code leaf decoder.
module tb_an13_decoder_1x1;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  an13_decoder_1x1_if bus ();

  an13_decoder_1x1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a word before the edge, then sample just after the edge it is captured on.
  task automatic drive(input logic [5:0] v);
    @(negedge clk);
    bus.IN0 = v;
    @(posedge clk);
    #1;
  endtask

  // Reference decode built from the powers of two, independent of any syndrome table.
  function automatic int ref_out(input int x);
    int r, e, p, c;
    r = x % 13;
    e = 0;
    for (int k = 0; k < 6; k++) begin
      p = 1 << k;
      if (r != 0 && (p % 13) == r)             e = p;
      else if (r != 0 && (13 - (p % 13)) == r) e = -p;
    end
    c = x - e;
    if (c >= 0 && c <= 52 && (c % 13) == 0) return c / 13;
    return x / 13;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.IN0 = 6'd52;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (bus.OUT0 !== 3'd0 || bus.DUT0_q !== 3'd0 || bus.DUT0_r !== 4'd0 || bus.DUT0_error !== 1'b0)
      $display("FAIL reset: out=%0d q=%0d r=%0d err=%0b required all 0",
               bus.OUT0, bus.DUT0_q, bus.DUT0_r, bus.DUT0_error);
    else n_pass++;
    @(negedge clk);
    rst_n   = 1'b1;
    bus.IN0 = 6'd0;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.OUT0 !== 3'd0 || bus.DUT0_error !== 1'b0)
      $display("FAIL post_reset_zero: out=%0d err=%0b required 0 0", bus.OUT0, bus.DUT0_error);
    else n_pass++;
  endtask

  task automatic test_clean();
    logic [5:0] ins [4];
    ins = '{6'd13, 6'd26, 6'd39, 6'd52};
    for (int i = 0; i < 4; i++) begin
      drive(ins[i]);
      n_total++;
      if (bus.OUT0 !== 3'(i + 1) || bus.DUT0_q !== 3'(i + 1) ||
          bus.DUT0_r !== 4'd0 || bus.DUT0_error !== 1'b0)
        $display("FAIL clean_%0d: out=%0d q=%0d r=%0d err=%0b required %0d %0d 0 0",
                 ins[i], bus.OUT0, bus.DUT0_q, bus.DUT0_r, bus.DUT0_error, i + 1, i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_bit01();
    logic [5:0] ins_a [5];
    logic [3:0] r_a   [5];
    logic [5:0] ins_b [5];
    ins_a = '{6'd1, 6'd12, 6'd27, 6'd38, 6'd53};
    r_a   = '{4'd1, 4'd12, 4'd1, 4'd12, 4'd1};
    ins_b = '{6'd2, 6'd15, 6'd24, 6'd37, 6'd54};
    for (int i = 0; i < 5; i++) begin
      drive(ins_a[i]);
      n_total++;
      if (bus.OUT0 !== 3'(i) || bus.DUT0_error !== 1'b1 || bus.DUT0_r !== r_a[i])
        $display("FAIL bit0_%0d: out=%0d err=%0b r=%0d required %0d 1 %0d",
                 ins_a[i], bus.OUT0, bus.DUT0_error, bus.DUT0_r, i, r_a[i]);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(ins_b[i]);
      n_total++;
      if (bus.OUT0 !== 3'(i) || bus.DUT0_error !== 1'b1)
        $display("FAIL bit1_%0d: out=%0d err=%0b required %0d 1",
                 ins_b[i], bus.OUT0, bus.DUT0_error, i);
      else n_pass++;
    end
  endtask

  task automatic test_bit23();
    logic [5:0] ins_a [5];
    logic [5:0] ins_b [5];
    ins_a = '{6'd4, 6'd9, 6'd30, 6'd35, 6'd48};
    ins_b = '{6'd8, 6'd5, 6'd18, 6'd47, 6'd60};
    for (int i = 0; i < 5; i++) begin
      drive(ins_a[i]);
      n_total++;
      if (bus.OUT0 !== 3'(i) || bus.DUT0_error !== 1'b1)
        $display("FAIL bit2_%0d: out=%0d err=%0b required %0d 1",
                 ins_a[i], bus.OUT0, bus.DUT0_error, i);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(ins_b[i]);
      n_total++;
      if (bus.OUT0 !== 3'(i) || bus.DUT0_error !== 1'b1)
        $display("FAIL bit3_%0d: out=%0d err=%0b required %0d 1",
                 ins_b[i], bus.OUT0, bus.DUT0_error, i);
      else n_pass++;
    end
    // 60 = 52 + 8: quotient and syndrome seen directly
    n_total++;
    if (bus.DUT0_q !== 3'd4 || bus.DUT0_r !== 4'd8)
      $display("FAIL qr_60: q=%0d r=%0d required 4 8", bus.DUT0_q, bus.DUT0_r);
    else n_pass++;
  endtask

  task automatic test_bit45();
    logic [5:0] ins_a [5];
    logic [5:0] ins_b [5];
    ins_a = '{6'd16, 6'd29, 6'd10, 6'd55, 6'd36};
    ins_b = '{6'd32, 6'd45, 6'd58, 6'd7, 6'd20};
    for (int i = 0; i < 5; i++) begin
      drive(ins_a[i]);
      n_total++;
      if (bus.OUT0 !== 3'(i) || bus.DUT0_error !== 1'b1)
        $display("FAIL bit4_%0d: out=%0d err=%0b required %0d 1",
                 ins_a[i], bus.OUT0, bus.DUT0_error, i);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(ins_b[i]);
      n_total++;
      if (bus.OUT0 !== 3'(i) || bus.DUT0_error !== 1'b1)
        $display("FAIL bit5_%0d: out=%0d err=%0b required %0d 1",
                 ins_b[i], bus.OUT0, bus.DUT0_error, i);
      else n_pass++;
    end
    drive(6'd58);
    n_total++;
    if (bus.DUT0_q !== 3'd4 || bus.DUT0_r !== 4'd6 || bus.OUT0 !== 3'd2)
      $display("FAIL qr_58: q=%0d r=%0d out=%0d required 4 6 2",
               bus.DUT0_q, bus.DUT0_r, bus.OUT0);
    else n_pass++;
  endtask

  task automatic test_uncorrectable();
    drive(6'd6);
    n_total++;
    if (bus.OUT0 !== 3'd0 || bus.DUT0_q !== 3'd0 || bus.DUT0_r !== 4'd6 || bus.DUT0_error !== 1'b1)
      $display("FAIL uncorr_6: out=%0d q=%0d r=%0d err=%0b required 0 0 6 1",
               bus.OUT0, bus.DUT0_q, bus.DUT0_r, bus.DUT0_error);
    else n_pass++;
    // 63: r=11 -> e=-2, c=65 out of range -> falls back to q=4
    drive(6'd63);
    n_total++;
    if (bus.OUT0 !== 3'd4 || bus.DUT0_r !== 4'd11 || bus.DUT0_error !== 1'b1)
      $display("FAIL uncorr_63: out=%0d r=%0d err=%0b required 4 11 1",
               bus.OUT0, bus.DUT0_r, bus.DUT0_error);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] prev_out;
    for (int x = 0; x < 64; x++) begin
      @(negedge clk);
      prev_out = bus.OUT0;
      bus.IN0  = 6'(x);
      if (x > 0) begin
        #1;
        // Output must still hold the previous word's result until the edge.
        n_total++;
        if (bus.OUT0 !== prev_out)
          $display("FAIL latency_%0d: out=%0d changed before edge, required %0d", x, bus.OUT0, prev_out);
        else n_pass++;
      end
      @(posedge clk);
      #1;
      n_total++;
      if (bus.DUT0_q !== 3'(x / 13) || bus.DUT0_r !== 4'(x % 13) ||
          bus.DUT0_error !== ((x % 13) != 0) || bus.OUT0 !== 3'(ref_out(x)))
        $display("FAIL sweep_%0d: q=%0d r=%0d err=%0b out=%0d required %0d %0d %0b %0d",
                 x, bus.DUT0_q, bus.DUT0_r, bus.DUT0_error, bus.OUT0,
                 x / 13, x % 13, (x % 13) != 0, ref_out(x));
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    drive(6'd53);
    n_total++;
    if (bus.OUT0 !== 3'd4 || bus.DUT0_error !== 1'b1)
      $display("FAIL pre_midreset: out=%0d err=%0b required 4 1", bus.OUT0, bus.DUT0_error);
    else n_pass++;
    @(negedge clk);
    rst_n   = 1'b0;
    bus.IN0 = 6'd58;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.OUT0 !== 3'd0 || bus.DUT0_q !== 3'd0 || bus.DUT0_r !== 4'd0 || bus.DUT0_error !== 1'b0)
      $display("FAIL midreset: out=%0d q=%0d r=%0d err=%0b required all 0",
               bus.OUT0, bus.DUT0_q, bus.DUT0_r, bus.DUT0_error);
    else n_pass++;
    @(negedge clk);
    rst_n   = 1'b1;
    bus.IN0 = 6'd39;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.OUT0 !== 3'd3 || bus.DUT0_q !== 3'd3 || bus.DUT0_r !== 4'd0 || bus.DUT0_error !== 1'b0)
      $display("FAIL post_midreset: out=%0d q=%0d r=%0d err=%0b required 3 3 0 0",
               bus.OUT0, bus.DUT0_q, bus.DUT0_r, bus.DUT0_error);
    else n_pass++;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    bus.IN0 = 6'd0;
    test_reset();
    test_clean();
    test_bit01();
    test_bit23();
    test_bit45();
    test_uncorrectable();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
